// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame shape, bit timing.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

   // One bit period in clocks, given the half-bit period.
   function automatic int bit_clks(input int h);
      return 2 * h;
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// Synchronous show-ahead FIFO: pop_data always presents the head entry.
// Pushes into a full FIFO and pops from an empty one are ignored.
module tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally; count tracks occupancy including simultaneous push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/transmitter.sv
// UART 8N1 transmit engine. Optional input FIFO enabled by TRANSMITTER_FIFO_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line high, waiting for a byte to load
// S_START | start bit (low) for one bit period
// S_DATA  | data bits LSB first, sh shifts right at each end-of-bit
// S_STOP  | stop bit (high); may reload in its last cycle for zero gap
module transmitter
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 5208,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_tx,
   input  logic       valid_tx,
   output logic       ready_tx,
   output logic       UART_TX,
   output logic       busy
);

   localparam logic [31:0] BIT_LAST = 32'(bit_clks(CLK_PER_HALF_BIT) - 1);
   localparam logic [2:0]  IDX_LAST = 3'(UART_DATA_BITS - 1);

   if ((CLK_PER_HALF_BIT < 2) || (FIFO_DEPTH < 2)) begin : g_param_check
      $error("transmitter: CLK_PER_HALF_BIT and FIFO_DEPTH must be >= 2");
   end

   tx_state_t   state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [2:0]  idx, idx_nxt;
   logic [7:0]  sh, sh_nxt;
   logic        tx_nxt;
   logic        tc;
   logic        load_ok;
   logic        load;
   logic [7:0]  load_data;

   assign tc      = (cnt == BIT_LAST);
   assign load_ok = (state == S_IDLE) || ((state == S_STOP) && tc);

`ifdef TRANSMITTER_FIFO_EN
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_head;

   // Readiness reflects fullness before any same-cycle pop.
   assign ready_tx  = !rst && !fifo_full;
   assign load      = load_ok && !fifo_empty;
   assign load_data = fifo_head;
   assign busy      = (state != S_IDLE) || !fifo_empty;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (valid_tx && ready_tx),
      .push_data (data_tx),
      .pop       (load),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );
`else
   assign ready_tx  = !rst && load_ok;
   assign load      = valid_tx && ready_tx;
   assign load_data = data_tx;
   assign busy      = (state != S_IDLE);
`endif

   // Next-state, bit timing and the registered line value.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = tc ? '0 : cnt + 32'd1;
      idx_nxt   = idx;
      sh_nxt    = sh;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (load) begin
               sh_nxt    = load_data;
               idx_nxt   = '0;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (tc) state_nxt = S_DATA;
         end
         S_DATA: begin
            if (tc) begin
               sh_nxt  = {1'b0, sh[7:1]};
               idx_nxt = idx + 3'd1;
               if (idx == IDX_LAST) state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (tc) begin
               if (load) begin
                  sh_nxt    = load_data;
                  idx_nxt   = '0;
                  cnt_nxt   = '0;
                  state_nxt = S_START;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      case (state_nxt)
         S_START: tx_nxt = 1'b0;
         S_DATA:  tx_nxt = sh_nxt[0];
         default: tx_nxt = 1'b1;
      endcase
   end

   // State, counters and line register; reset drives the line idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx     <= '0;
         sh      <= '0;
         UART_TX <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         sh      <= sh_nxt;
         UART_TX <= tx_nxt;
      end
   end

endmodule

// File: doc/transmitter.md
# transmitter

UART transmit engine, 8N1 framing, the transmit-side counterpart of the core's UART receive path. Accepts bytes from the core over a valid/ready handshake and serialises them onto `UART_TX`, LSB first, at a bit period of `2*CLK_PER_HALF_BIT` clocks. An optional small FIFO decouples the core from line rate.

## Interface
- `CLK_PER_HALF_BIT`, 5208: half bit period in clocks. Bit period is `2*CLK_PER_HALF_BIT` clocks. Must be ≥ 2.
- `FIFO_DEPTH`, 4: FIFO entries, power of 2, ≥ 2. Only used with `TRANSMITTER_FIFO_EN`.

Ports:
- `clk` in 1: sole clock. All logic is on `posedge clk`.
- `rst` in 1: asynchronous, active-high reset.
- `data_tx` in 8: byte to send. Sampled on handshake.
- `valid_tx` in 1: `data_tx` is valid.
- `ready_tx` out 1: block accepts a byte this cycle. Forced 0 while `rst` is high.
- `UART_TX` out 1: serial line, registered, idle high.
- `busy` out 1: frame on the line, or FIFO non-empty.

## Operation
- Handshake: a byte is transferred when `valid_tx && ready_tx` at a `posedge clk`. `data_tx` is ignored otherwise.
- State machine, one-hot or encoded. States `S_IDLE`, `S_START`, `S_DATA`, `S_STOP`.
  - `S_IDLE`: `UART_TX`=1. On load, latch the byte into shift register `sh[7:0]`, clear the bit counter, clear the 3-bit index, then go to `S_START`.
  - `S_START`: `UART_TX`=0 for one bit period, then go to `S_DATA`.
  - `S_DATA`: `UART_TX`=`sh[0]`. At the end of each bit period, `sh` shifts right. After index 7 the FSM goes to `S_STOP`. The index increments mod 8.
  - `S_STOP`: `UART_TX`=1 for one bit period. At the end, reload if a byte is available, otherwise go to `S_IDLE`.
- Bit counter: 32-bit, counts 0 to `2*CLK_PER_HALF_BIT-1`, then wraps to 0. The terminal count marks end-of-bit. It is cleared on every load.
- Load source:
  - Without FIFO: the handshake itself.
  - With FIFO: FIFO head when non-empty.
- Load is possible in `S_IDLE`, or in the last cycle of `S_STOP`. The last case gives back-to-back frames with zero idle gap.
- Reset, including mid-frame: `UART_TX`=1 immediately. State goes to `S_IDLE`, counters clear, and the FIFO empties. The partial frame is abandoned.
- Reset values: `UART_TX`=1, `busy`=0, `ready_tx`=0 while `rst` is asserted.

## Timing
- No FIFO:
  - `ready_tx` = (`S_IDLE`) or (`S_STOP` and terminal count).
  - Accepted at edge N: start bit is on `UART_TX` from cycle N+1.
- Frame length: exactly `20*CLK_PER_HALF_BIT` clocks from start-bit edge to end of stop bit.
- Data bit k (k = 0..7) occupies cycles `(k+1)*2H` to `(k+2)*2H-1` relative to the start-bit edge, where H = `CLK_PER_HALF_BIT`.
- With FIFO:
  - `ready_tx` = !full. It is computed before any same-cycle pop, so a push into a full FIFO is refused even if a pop occurs.
  - A push at edge N into an empty FIFO with an idle engine gives a start bit from N+2.
  - Simultaneous push and pop at non-full: both occur, and the count is unchanged.
- Boundaries:
  - Full: no push, FIFO contents unchanged.
  - Empty at the last `S_STOP` cycle: go to `S_IDLE`.
  - Pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is `$clog2(FIFO_DEPTH)+1` bits.

## Configuration
- Macro: `TRANSMITTER_FIFO_EN`.
- Defined: the `FIFO_DEPTH`-entry FIFO is instantiated between the handshake and the engine. `busy` also covers a non-empty FIFO.
- Undefined: no storage beyond `sh`. `ready_tx` is driven by the FSM as above. `FIFO_DEPTH` is unused.

## Structure
- Package `uart_pkg` holds:
  - the `tx_state_t` enum (`S_IDLE`, `S_START`, `S_DATA`, `S_STOP`);
  - the frame constants `UART_DATA_BITS`=8 and `UART_STOP_BITS`=1;
  - the bit-period function `bit_clks(h) = 2*h`.
- Sub-module `tx_fifo`: synchronous show-ahead FIFO with the same `clk`/`rst`. Ports are push/pop/full/empty/data. It is instantiated only under `TRANSMITTER_FIFO_EN`.

## Test plan
All scenarios use `CLK_PER_HALF_BIT`=4, so bit = 8 clocks and frame = 80 clocks.
- Single byte: send 0xA5 from idle.
  - `UART_TX` = 0 for 8 clocks, then 1,0,1,0,0,1,0,1 at 8 clocks each, then 1 for 8 clocks.
  - `ready_tx` is low from N+1 until the last stop cycle.
- Back-to-back: send 0x00 then 0xFF with `valid_tx` held high.
  - The second start bit immediately follows the first stop bit, with no idle cycle.
  - Total 160 clocks low-to-idle.
- Backpressure, no FIFO: `valid_tx` high mid-frame with 0x3C.
  - No handshake until the stop-bit terminal cycle.
  - `data_tx` changes before that are ignored.
- Reset mid-frame: assert `rst` during data bit 3 of 0x55.
  - `UART_TX`=1 asynchronously, `busy`=0.
  - After release, a new 0x81 is sent correctly.
- FIFO, with `TRANSMITTER_FIFO_EN` and `FIFO_DEPTH`=4:
  - Push 5 bytes 0x11..0x15 in consecutive cycles.
  - `ready_tx` drops after the FIFO fills. 0x15 is accepted only after the first pop.
  - Line order is 0x11..0x15, with no gaps between frames.
- Loopback: connect `UART_TX` to the receiver instance with the same `CLK_PER_HALF_BIT` and send 256 sequential bytes.
  - Every byte is received equal and in order.
